// File: rtl/ppu_tile_scheduler.sv
// ppu_tile_scheduler: frame-level sequencer for the VRAM load FSM.
// Walks every background tile in raster order. For each tile it optionally
// scans OAM for the first overlapping sprite, presents tile/sprite data,
// pulses load_start and then waits (with a timeout) for the load to finish.
module ppu_tile_scheduler #(
    parameter int TILE_COLS    = 32,
    parameter int TILE_ROWS    = 30,
    parameter int NUM_SPRITES  = 64,
    parameter int LOAD_TIMEOUT = 511
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        frame_start,
    input  logic [7:0]  ppu_ctrl1,
    input  logic [7:0]  ppu_ctrl2,
    output logic [7:0]  oam_addr,
    input  logic [7:0]  oam_data,
    output logic        load_start,
    input  logic        load_busy,
    output logic [8:0]  curr_row,
    output logic [8:0]  curr_col,
    output logic [15:0] nametable_ptr,
    output logic        sprite_on_tile,
    output logic [15:0] sprite_pattern_base,
    output logic [15:0] background_pattern_base,
    output logic [7:0]  sprite_tile_num,
    output logic [7:0]  sprite_row,
    output logic [7:0]  sprite_col,
    output logic [7:0]  sprite_attr,
    output logic [7:0]  ppu_ctrl2_out,
    output logic        frame_busy,
    output logic        frame_done,
    output logic        load_error
);
    localparam int COL_W  = $clog2(TILE_COLS);
    localparam int ROW_W  = $clog2(TILE_ROWS);
    localparam int SPR_W  = $clog2(NUM_SPRITES);
    localparam int WAIT_W = $clog2(LOAD_TIMEOUT + 1);
    localparam logic [COL_W-1:0]  LAST_COL  = COL_W'(TILE_COLS - 1);
    localparam logic [ROW_W-1:0]  LAST_ROW  = ROW_W'(TILE_ROWS - 1);
    localparam logic [SPR_W-1:0]  LAST_SPR  = SPR_W'(NUM_SPRITES - 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(LOAD_TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE, SCAN_INIT, SCAN, LAUNCH, WAIT_ACK, WAIT_DONE, NEXT, DONE
    } state_t;

    state_t             state, state_nxt;
    logic [7:0]         ctrl1_q;
    logic [ROW_W-1:0]   tile_row, row_nxt;
    logic [COL_W-1:0]   tile_col, col_nxt;
    logic [SPR_W-1:0]   spr_idx;
    logic [2:0]         phase;        // 0..3 address cycles, 4 = compare
    logic [7:0]         cap_y, cap_tile, cap_attr;
    logic [WAIT_W-1:0]  wait_cnt;
    logic               hit, last_tile, timeout;
    logic [9:0]         y10, x10, r10, c10;
    logic [15:0]        ptr_nxt;

    // OAM byte address follows the scan position; phase 4 re-reads harmlessly
    assign oam_addr = 8'({spr_idx, phase[1:0]});
    assign sprite_pattern_base     = ctrl1_q[3] ? 16'h1000 : 16'h0000;
    assign background_pattern_base = ctrl1_q[4] ? 16'h1000 : 16'h0000;

    // Overlap test in 10-bit unsigned so Y+8 / X+8 never wrap; X arrives live
    always_comb begin
        y10 = {2'b00, cap_y};
        x10 = {2'b00, oam_data};
        r10 = {1'b0, curr_row};
        c10 = {1'b0, curr_col};
        hit = (cap_y < 8'hF0) &&
              (y10 + 10'd8 > r10) && (y10 < r10 + 10'd8) &&
              (x10 + 10'd8 > c10) && (x10 < c10 + 10'd8);
    end

    // Next raster position and its nametable address
    always_comb begin
        last_tile = (tile_row == LAST_ROW) && (tile_col == LAST_COL);
        if (tile_col == LAST_COL) begin
            col_nxt = '0;
            row_nxt = tile_row + 1'b1;
        end else begin
            col_nxt = tile_col + 1'b1;
            row_nxt = tile_row;
        end
        ptr_nxt = 16'h2000 + {4'b0000, ctrl1_q[1:0], 10'b0}
                + 16'(row_nxt) * 16'(TILE_COLS) + 16'(col_nxt);
    end

    // A normal completion in WAIT_DONE beats the timeout on the same cycle
    assign timeout = ((state == WAIT_ACK) || (state == WAIT_DONE && load_busy))
                     && (wait_cnt == WAIT_LAST);

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:      if (frame_start)
                           state_nxt = (ppu_ctrl2[4:3] == 2'b00) ? DONE : SCAN_INIT;
            SCAN_INIT: state_nxt = ppu_ctrl2_out[4] ? SCAN : LAUNCH;
            SCAN:      if (phase == 3'd4 && (hit || spr_idx == LAST_SPR))
                           state_nxt = LAUNCH;
            LAUNCH:    state_nxt = WAIT_ACK;
            WAIT_ACK:  if (timeout)        state_nxt = NEXT;
                       else if (load_busy) state_nxt = WAIT_DONE;
            WAIT_DONE: if (timeout || !load_busy) state_nxt = NEXT;
            NEXT:      state_nxt = last_tile ? DONE : SCAN_INIT;
            DONE:      state_nxt = IDLE;
            default:   state_nxt = IDLE;
        endcase
    end

    // Datapath: control latching, tile walk, OAM capture, wait counter, flags
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ctrl1_q         <= '0;
            ppu_ctrl2_out   <= '0;
            tile_row        <= '0;
            tile_col        <= '0;
            curr_row        <= '0;
            curr_col        <= '0;
            nametable_ptr   <= '0;
            spr_idx         <= '0;
            phase           <= '0;
            cap_y           <= '0;
            cap_tile        <= '0;
            cap_attr        <= '0;
            wait_cnt        <= '0;
            sprite_on_tile  <= 1'b0;
            sprite_tile_num <= '0;
            sprite_row      <= '0;
            sprite_col      <= '0;
            sprite_attr     <= '0;
            load_start      <= 1'b0;
            frame_busy      <= 1'b0;
            frame_done      <= 1'b0;
            load_error      <= 1'b0;
        end else begin
            load_start <= 1'b0;
            frame_done <= 1'b0;
            case (state)
                IDLE: if (frame_start) begin
                    ctrl1_q       <= ppu_ctrl1;
                    ppu_ctrl2_out <= ppu_ctrl2;
                    tile_row      <= '0;
                    tile_col      <= '0;
                    curr_row      <= '0;
                    curr_col      <= '0;
                    nametable_ptr <= 16'h2000 + {4'b0000, ppu_ctrl1[1:0], 10'b0};
                    load_error    <= 1'b0;
                    frame_busy    <= 1'b1;
                end
                SCAN_INIT: begin
                    spr_idx <= '0;
                    phase   <= '0;
                    if (!ppu_ctrl2_out[4]) begin
                        sprite_on_tile  <= 1'b0;
                        sprite_tile_num <= '0;
                        sprite_row      <= '0;
                        sprite_col      <= '0;
                        sprite_attr     <= '0;
                    end
                end
                SCAN: begin
                    case (phase)
                        3'd1:    cap_y    <= oam_data;
                        3'd2:    cap_tile <= oam_data;
                        3'd3:    cap_attr <= oam_data;
                        default: ;
                    endcase
                    if (phase != 3'd4) begin
                        phase <= phase + 3'd1;
                    end else if (hit) begin
                        sprite_on_tile  <= 1'b1;
                        sprite_tile_num <= cap_tile;
                        sprite_row      <= cap_y;
                        sprite_col      <= oam_data;
                        sprite_attr     <= cap_attr;
                    end else if (spr_idx == LAST_SPR) begin
                        sprite_on_tile  <= 1'b0;
                        sprite_tile_num <= '0;
                        sprite_row      <= '0;
                        sprite_col      <= '0;
                        sprite_attr     <= '0;
                    end else begin
                        spr_idx <= spr_idx + 1'b1;
                        phase   <= '0;
                    end
                end
                LAUNCH: begin
                    load_start <= 1'b1;
                    wait_cnt   <= '0;
                end
                WAIT_ACK, WAIT_DONE: begin
                    wait_cnt <= wait_cnt + 1'b1;
                    if (timeout) load_error <= 1'b1;
                end
                NEXT: if (!last_tile) begin
                    tile_row      <= row_nxt;
                    tile_col      <= col_nxt;
                    curr_row      <= 9'({row_nxt, 3'b000});
                    curr_col      <= 9'({col_nxt, 3'b000});
                    nametable_ptr <= ptr_nxt;
                end
                DONE: begin
                    frame_done <= 1'b1;
                    frame_busy <= 1'b0;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_ppu_tile_scheduler.sv
// Bench for ppu_tile_scheduler: OAM memory and a randomized load FSM model,
// with every launched tile checked against a raster/overlap reference model.
module tb_ppu_tile_scheduler;
    localparam int LOAD_TIMEOUT = 511;

    logic        clk = 1'b0, rst = 1'b0, frame_start = 1'b0;
    logic [7:0]  ppu_ctrl1 = '0, ppu_ctrl2 = '0, oam_data = '0;
    logic        load_busy = 1'b0;
    logic [7:0]  oam_addr, sprite_tile_num, sprite_row, sprite_col, sprite_attr, ppu_ctrl2_out;
    logic        load_start, sprite_on_tile, frame_busy, frame_done, load_error;
    logic [8:0]  curr_row, curr_col;
    logic [15:0] nametable_ptr, sprite_pattern_base, background_pattern_base;

    ppu_tile_scheduler dut (
        .clk(clk), .rst(rst), .frame_start(frame_start),
        .ppu_ctrl1(ppu_ctrl1), .ppu_ctrl2(ppu_ctrl2),
        .oam_addr(oam_addr), .oam_data(oam_data),
        .load_start(load_start), .load_busy(load_busy),
        .curr_row(curr_row), .curr_col(curr_col), .nametable_ptr(nametable_ptr),
        .sprite_on_tile(sprite_on_tile), .sprite_pattern_base(sprite_pattern_base),
        .background_pattern_base(background_pattern_base),
        .sprite_tile_num(sprite_tile_num), .sprite_row(sprite_row),
        .sprite_col(sprite_col), .sprite_attr(sprite_attr),
        .ppu_ctrl2_out(ppu_ctrl2_out), .frame_busy(frame_busy),
        .frame_done(frame_done), .load_error(load_error)
    );

    always #5 clk = ~clk;

    // OAM: synchronous read, data one cycle after the address
    logic [7:0] oam [0:255];
    always @(posedge clk) oam_data <= oam[oam_addr];

    // Load FSM model: mode 0 never goes busy; mode 1 goes busy after 0..3
    // cycles for 1..5 cycles
    int   ld_mode = 1;
    int   ld_dly = 0, ld_len = 0;
    logic ld_pend = 1'b0;
    always @(posedge clk) begin
        if (!rst) begin
            load_busy <= 1'b0;
            ld_pend   <= 1'b0;
        end else if (load_start && ld_mode == 1) begin
            ld_pend <= 1'b1;
            ld_dly  <= $urandom_range(0, 3);
            ld_len  <= $urandom_range(1, 5);
        end else if (ld_pend) begin
            if (ld_dly > 0) ld_dly <= ld_dly - 1;
            else begin
                load_busy <= 1'b1;
                ld_pend   <= 1'b0;
            end
        end else if (load_busy) begin
            if (ld_len > 1) ld_len <= ld_len - 1;
            else            load_busy <= 1'b0;
        end
    end

    int tests = 0, fails = 0;
    int tile_idx = 0, frame_loads = 0, n_done = 0;
    int since_fall = 0, since_ls = 0, gap_mode = 0, watch_idx = -1;
    logic prev_busy = 1'b0;
    logic [7:0]  m_ctrl1 = '0, m_ctrl2 = '0;
    logic [15:0] first_ptr = '0, last_ptr = '0;
    logic [15:0] watch_rc = '0;
    logic [33:0] prev_a = '0;
    logic [32:0] prev_s = '0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic bit overlaps(int n, int row, int col);
        int y, x;
        y = oam[4*n];
        x = oam[4*n+3];
        return (y < 240) && (y + 8 > row) && (y < row + 8) && (x + 8 > col) && (x < col + 8);
    endfunction

    function automatic int find_sprite(int row, int col);
        for (int n = 0; n < 64; n++)
            if (overlaps(n, row, col)) return n;
        return -1;
    endfunction

    // One clock: sample at the falling edge and check every launched tile
    task automatic step();
        int r, c, n, scan, nt;
        logic [63:0] exp_spr, exp_base;
        @(negedge clk);
        since_ls++;
        if (prev_busy && !load_busy) since_fall = 0;
        else                         since_fall++;
        prev_busy = load_busy;
        if (!rst) tile_idx = 0;
        if (load_start) begin
            r  = tile_idx / 32;
            c  = tile_idx % 32;
            nt = int'(m_ctrl1[1:0]);
            n  = m_ctrl2[4] ? find_sprite(r * 8, c * 8) : -1;
            scan = !m_ctrl2[4] ? 0 : (n >= 0 ? 5 * (n + 1) : 5 * 64);
            exp_spr  = (n >= 0) ? {31'd0, 1'b1, oam[4*n+1], oam[4*n], oam[4*n+3], oam[4*n+2]} : 64'd0;
            exp_base = {24'd0, (m_ctrl1[3] ? 16'h1000 : 16'h0000),
                        (m_ctrl1[4] ? 16'h1000 : 16'h0000), m_ctrl2};
            check("nametable_ptr", nametable_ptr, 64'(32'h2000 + nt * 1024 + tile_idx));
            check("curr_row_col", {curr_row, curr_col}, 64'({9'(r * 8), 9'(c * 8)}));
            check("sprite_outputs", {sprite_on_tile, sprite_tile_num, sprite_row, sprite_col, sprite_attr}, exp_spr);
            check("bases_ctrl2", {sprite_pattern_base, background_pattern_base, ppu_ctrl2_out}, exp_base);
            check("stable_tile", {nametable_ptr, curr_row, curr_col}, prev_a);
            check("stable_sprite", {sprite_on_tile, sprite_tile_num, sprite_row, sprite_col, sprite_attr}, prev_s);
            check("no_overlap_load", {load_busy, ld_pend}, 0);
            if (gap_mode == 1 && tile_idx > 0) check("scan_gap", since_fall, 4 + scan);
            if (gap_mode == 2 && tile_idx > 0) begin
                check("timeout_gap", since_ls, LOAD_TIMEOUT + 3 + scan);
                check("load_error_sticky", load_error, 1);
            end
            if (tile_idx == 0) first_ptr = nametable_ptr;
            if (tile_idx == watch_idx) watch_rc = {sprite_row, sprite_col};
            last_ptr = nametable_ptr;
            tile_idx++;
            since_ls = 0;
        end
        if (frame_done) begin
            frame_loads = tile_idx;
            n_done++;
            tile_idx = 0;
        end
        prev_a = {nametable_ptr, curr_row, curr_col};
        prev_s = {sprite_on_tile, sprite_tile_num, sprite_row, sprite_col, sprite_attr};
    endtask

    task automatic start_frame(input logic [7:0] c1, input logic [7:0] c2);
        ppu_ctrl1 = c1; ppu_ctrl2 = c2;
        m_ctrl1 = c1;   m_ctrl2 = c2;
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
        check("busy_after_start", frame_busy, 1);
        check("load_error_cleared", load_error, 0);
    endtask

    task automatic wait_done(input int budget);
        int d0, k;
        d0 = n_done;
        k  = 0;
        while (n_done == d0 && k < budget) begin
            step();
            k++;
        end
        check("frame_done_seen", n_done, d0 + 1);
        check("busy_low_at_done", frame_busy, 0);
        step();
        check("done_one_cycle", {frame_done, frame_busy}, 0);
    endtask

    task automatic run_loads(input int cnt, input int budget);
        int k;
        k = 0;
        while (tile_idx < cnt && k < budget) begin
            step();
            k++;
        end
        check("loads_reached", tile_idx >= cnt, 1);
    endtask

    task automatic reset_pulse();
        rst = 1'b0;
        step();
        rst = 1'b1;
    endtask

    initial begin
        logic [7:0] rc1, rc2;
        for (int i = 0; i < 256; i++) oam[i] = 8'hF0;

        // Reset state
        step();
        check("reset_grp_a", {nametable_ptr, sprite_pattern_base, background_pattern_base, ppu_ctrl2_out, oam_addr}, 0);
        check("reset_grp_b", {load_start, curr_row, curr_col, sprite_on_tile, sprite_tile_num, sprite_row,
                              sprite_col, sprite_attr, frame_busy, frame_done, load_error}, 0);
        rst = 1'b1;
        step();

        // Background-only frame, randomized load latency
        ld_mode = 1; gap_mode = 1;
        start_frame(8'h10, 8'h08);
        wait_done(20000);
        check("t1_loads", frame_loads, 960);
        check("t1_first_ptr", first_ptr, 16'h2000);
        check("t1_last_ptr", last_ptr, 16'h23BF);
        check("t1_bg_base", background_pattern_base, 16'h1000);
        check("t1_load_error", load_error, 0);

        // Single sprite at Y=0,X=3 spanning tiles (0,0) and (0,1)
        for (int i = 0; i < 64; i++) begin
            oam[4*i] = 8'hF0; oam[4*i+1] = 8'($urandom); oam[4*i+2] = 8'($urandom); oam[4*i+3] = 8'($urandom);
        end
        oam[0] = 8'h00; oam[1] = 8'h01; oam[2] = 8'h00; oam[3] = 8'h03;
        watch_idx = 1;
        start_frame(8'h08, 8'h18);
        run_loads(3, 3000);
        check("t2_tile01_sprite", watch_rc, 16'h0003);

        // Asynchronous reset in the middle of a sprite scan
        for (int i = 0; i < 40; i++) step();
        check("t6_busy_before_rst", frame_busy, 1);
        #2 rst = 1'b0;
        #1;
        check("t6_async_grp_a", {nametable_ptr, sprite_pattern_base, background_pattern_base, ppu_ctrl2_out, oam_addr}, 0);
        check("t6_async_grp_b", {load_start, curr_row, curr_col, sprite_on_tile, sprite_tile_num, sprite_row,
                                 sprite_col, sprite_attr, frame_busy, frame_done, load_error}, 0);
        step();
        rst = 1'b1;
        for (int i = 0; i < 5; i++) step();
        check("t6_idle_after_rst", {frame_busy, load_start}, 0);

        // Random OAM; sprites 5 and 9 both overlap tile (2,4)
        for (int i = 0; i < 64; i++) begin
            oam[4*i]   = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(16, 255)) : 8'hF0;
            oam[4*i+1] = 8'($urandom); oam[4*i+2] = 8'($urandom); oam[4*i+3] = 8'($urandom);
        end
        oam[20] = 8'd14; oam[23] = 8'd35;
        oam[36] = 8'd18; oam[39] = 8'd30;
        for (int i = 0; i < 5; i++) if (overlaps(i, 16, 32)) oam[4*i] = 8'hF0;
        watch_idx = 68;
        start_frame(8'h00, 8'h18);
        run_loads(70, 30000);
        check("t6_restart_ptr", first_ptr, 16'h2000);
        check("t3_first_match", watch_rc, {8'd14, 8'd35});
        watch_idx = -1;
        reset_pulse();
        step();

        // Load FSM never responds: tiles advance on timeout
        ld_mode = 0; gap_mode = 2;
        start_frame(8'h10, 8'h08);
        run_loads(3, 2000);
        gap_mode = 0; ld_mode = 1;
        wait_done(25000);
        check("t4_loads", frame_loads, 960);
        check("t4_load_error", load_error, 1);

        // Both layers disabled: immediate done, error cleared, no loads
        start_frame(8'h10, 8'h00);
        check("t5_done_not_early", frame_done, 0);
        step();
        check("t5_done_2_cycles", frame_done, 1);
        check("t5_zero_loads", frame_loads, 0);
        step();

        // Nametable 2, controls changed and frame_start pulsed mid-frame
        gap_mode = 1;
        rc1 = 8'($urandom);
        rc2 = 8'($urandom);
        start_frame({rc1[7:2], 2'b10}, {rc2[7:5], 2'b01, rc2[2:0]});
        for (int i = 0; i < 100; i++) step();
        ppu_ctrl1 = 8'($urandom); ppu_ctrl2 = 8'($urandom);
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
        ppu_ctrl1 = 8'($urandom); ppu_ctrl2 = 8'($urandom);
        wait_done(20000);
        check("t5_loads", frame_loads, 960);
        check("t5_first_ptr", first_ptr, 16'h2800);
        for (int i = 0; i < 5; i++) step();
        check("t5_no_extra_frame", frame_busy, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
